// File: rtl/pq_arb_pkg.sv
// Shared types for the pheap front-end arbiter: FSM states and operation class.
package pq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef enum logic {
        ENQ = 1'b0,
        DEQ = 1'b1
    } class_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest-index requester at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Scan from ptr upward with wrap; the first hit is kept.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            int  j;
            logic hit;
            j       = (int'(ptr) + i) % N;
            hit     = !any && req[j];
            gnt_idx = hit ? IW'(j) : gnt_idx;
            any     = any | hit;
        end
    end

endmodule

// File: rtl/pq_arbiter.sv
// Serialises per-core enq/deq requests onto the single pheap port,
// alternating classes under contention and round-robin within each class.
module pq_arbiter
    import pq_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        enq_req,
    input  logic [NUM_CORES*DWIDTH-1:0] enq_data,
    output logic [NUM_CORES-1:0]        enq_ack,
    input  logic [NUM_CORES-1:0]        deq_req,
    output logic [NUM_CORES-1:0]        deq_valid,
    output logic [DWIDTH-1:0]           deq_data,
    output logic                        pq_enq,
    output logic                        pq_deq,
    output logic [DWIDTH-1:0]           pq_inp_data,
    input  logic [DWIDTH-1:0]           pq_out_data,
    input  logic                        pq_ready,
    input  logic                        pq_full,
    input  logic                        pq_empty
);

    localparam int IW = $clog2(NUM_CORES);

    state_e                state_q, state_d;
    class_e                last_class_q, last_class_d;
    class_e                gnt_class_q, gnt_class_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [IW-1:0]         enq_ptr_q, enq_ptr_d;
    logic [IW-1:0]         deq_ptr_q, deq_ptr_d;
    logic [NUM_CORES-1:0]  enq_ack_q, enq_ack_d;
    logic [NUM_CORES-1:0]  deq_valid_q, deq_valid_d;
    logic                  pq_enq_q, pq_enq_d;
    logic                  pq_deq_q, pq_deq_d;
    logic [DWIDTH-1:0]     pq_inp_data_q, pq_inp_data_d;
    logic [DWIDTH-1:0]     deq_data_q, deq_data_d;

    logic [IW-1:0] enq_idx_s, deq_idx_s;
    logic          enq_any_s, deq_any_s;
    logic          enq_elig_s, deq_elig_s;
    logic [IW-1:0] gnt_next_s;

    rr_arbiter #(.N(NUM_CORES)) u_enq_rr (
        .req     (enq_req),
        .ptr     (enq_ptr_q),
        .gnt_idx (enq_idx_s),
        .any     (enq_any_s)
    );

    rr_arbiter #(.N(NUM_CORES)) u_deq_rr (
        .req     (deq_req),
        .ptr     (deq_ptr_q),
        .gnt_idx (deq_idx_s),
        .any     (deq_any_s)
    );

    assign enq_elig_s = enq_any_s && !pq_full;
    assign deq_elig_s = deq_any_s && !pq_empty;
    assign gnt_next_s = (gnt_q == IW'(NUM_CORES - 1)) ? '0 : gnt_q + IW'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        last_class_d  = last_class_q;
        gnt_class_d   = gnt_class_q;
        gnt_d         = gnt_q;
        enq_ptr_d     = enq_ptr_q;
        deq_ptr_d     = deq_ptr_q;
        enq_ack_d     = '0;
        deq_valid_d   = '0;
        pq_enq_d      = 1'b0;
        pq_deq_d      = 1'b0;
        pq_inp_data_d = pq_inp_data_q;
        deq_data_d    = deq_data_q;
        case (state_q)
            IDLE: begin
                if (pq_ready && (enq_elig_s || deq_elig_s)) begin
                    // Under contention, take the class opposite the last one served.
                    if (enq_elig_s && (!deq_elig_s || last_class_q == DEQ)) begin
                        gnt_class_d   = ENQ;
                        gnt_d         = enq_idx_s;
                        pq_enq_d      = 1'b1;
                        enq_ack_d     = NUM_CORES'(1) << enq_idx_s;
                        pq_inp_data_d = enq_data[int'(enq_idx_s)*DWIDTH +: DWIDTH];
                    end else begin
                        gnt_class_d = DEQ;
                        gnt_d       = deq_idx_s;
                        pq_deq_d    = 1'b1;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                last_class_d = gnt_class_q;
                if (gnt_class_q == ENQ) begin
                    enq_ptr_d = gnt_next_s;
                end else begin
                    deq_ptr_d   = gnt_next_s;
                    deq_data_d  = pq_out_data;
                    deq_valid_d = NUM_CORES'(1) << gnt_q;
                end
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; rst_n is active-high in this codebase.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= IDLE;
            last_class_q  <= DEQ;
            gnt_class_q   <= ENQ;
            gnt_q         <= '0;
            enq_ptr_q     <= '0;
            deq_ptr_q     <= '0;
            enq_ack_q     <= '0;
            deq_valid_q   <= '0;
            pq_enq_q      <= 1'b0;
            pq_deq_q      <= 1'b0;
            pq_inp_data_q <= '0;
            deq_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_class_q  <= last_class_d;
            gnt_class_q   <= gnt_class_d;
            gnt_q         <= gnt_d;
            enq_ptr_q     <= enq_ptr_d;
            deq_ptr_q     <= deq_ptr_d;
            enq_ack_q     <= enq_ack_d;
            deq_valid_q   <= deq_valid_d;
            pq_enq_q      <= pq_enq_d;
            pq_deq_q      <= pq_deq_d;
            pq_inp_data_q <= pq_inp_data_d;
            deq_data_q    <= deq_data_d;
        end
    end

    assign enq_ack     = enq_ack_q;
    assign deq_valid   = deq_valid_q;
    assign deq_data    = deq_data_q;
    assign pq_enq      = pq_enq_q;
    assign pq_deq      = pq_deq_q;
    assign pq_inp_data = pq_inp_data_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter with a small behavioural min-heap standing in for pheap.
module tb_pq_arbiter;

    localparam int NC  = 4;
    localparam int DW  = 32;
    localparam int CAP = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NC-1:0]   enq_req = '0;
    logic [NC*DW-1:0] enq_data = '0;
    logic [NC-1:0]   enq_ack;
    logic [NC-1:0]   deq_req = '0;
    logic [NC-1:0]   deq_valid;
    logic [DW-1:0]   deq_data;
    logic            pq_enq, pq_deq;
    logic [DW-1:0]   pq_inp_data, pq_out_data;
    logic            pq_ready, pq_full, pq_empty;

    logic            ready_r = 1'b1;
    logic            force_full = 1'b0;
    logic            heap_clr = 1'b1;
    logic [DW-1:0]   hp [CAP];
    int              hcnt;
    logic [DW-1:0]   minv;
    int              mini;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pq_arbiter #(.NUM_CORES(NC), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_req(enq_req), .enq_data(enq_data), .enq_ack(enq_ack),
        .deq_req(deq_req), .deq_valid(deq_valid), .deq_data(deq_data),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_inp_data(pq_inp_data),
        .pq_out_data(pq_out_data), .pq_ready(pq_ready),
        .pq_full(pq_full), .pq_empty(pq_empty)
    );

    // Behavioural heap: unsorted store, minimum found combinationally.
    always_comb begin
        minv = '1;
        mini = 0;
        for (int i = 0; i < CAP; i++) begin
            if (i < hcnt && hp[i] < minv) begin
                minv = hp[i];
                mini = i;
            end
        end
    end

    assign pq_out_data = (hcnt == 0) ? '0 : minv;
    assign pq_empty    = (hcnt == 0);
    assign pq_full     = (hcnt >= CAP) || force_full;
    assign pq_ready    = ready_r;

    always @(posedge clk) begin
        if (heap_clr) begin
            hcnt <= 0;
        end else if (pq_enq && hcnt < CAP) begin
            hp[hcnt] <= pq_inp_data;
            hcnt     <= hcnt + 1;
        end else if (pq_deq && hcnt > 0) begin
            hp[mini] <= hp[hcnt-1];
            hcnt     <= hcnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b1;
        heap_clr = 1'b1;
        step();
        step();
        rst_n    = 1'b0;
        heap_clr = 1'b0;
    endtask

    // Enqueue from one core starting in IDLE; returns with the FSM back in IDLE.
    task automatic do_enq(input int core, input logic [DW-1:0] data);
        int lat = 0;
        enq_req[core] = 1'b1;
        enq_data[core*DW +: DW] = data;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (enq_ack != '0) begin
                lat = k;
                break;
            end
        end
        chk("enq_latency", 64'(lat), 64'd1);
        chk("enq_ack", 64'(enq_ack), 64'(4'b0001 << core));
        chk("pq_enq", 64'(pq_enq), 64'd1);
        chk("pq_inp_data", 64'(pq_inp_data), 64'(data));
        enq_req[core] = 1'b0;
        step();
        chk("enq_ack_pulse", 64'({pq_enq, enq_ack}), 64'd0);
        step();
    endtask

    // Dequeue from one core starting in IDLE; returns with the FSM back in IDLE.
    task automatic do_deq(input int core, input logic [DW-1:0] exp);
        int lat = 0;
        deq_req[core] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pq_deq) begin
                lat = k;
                break;
            end
        end
        chk("deq_latency", 64'(lat), 64'd1);
        step();
        chk("deq_valid", 64'(deq_valid), 64'(4'b0001 << core));
        chk("deq_data", 64'(deq_data), 64'(exp));
        chk("deq_gap_strobe", 64'(pq_deq), 64'd0);
        deq_req[core] = 1'b0;
        step();
    endtask

    initial begin
        // Reset values
        step();
        chk("rst_outputs", 64'({enq_ack, deq_valid, pq_enq, pq_deq}), 64'd0);
        chk("rst_inp_data", 64'(pq_inp_data), 64'd0);
        chk("rst_deq_data", 64'(deq_data), 64'd0);
        rst_n    = 1'b0;
        heap_clr = 1'b0;
        step();

        // Single enq then deq
        do_enq(2, 32'h0000_0007);
        do_deq(0, 32'h0000_0007);

        // Ordering through the heap
        do_enq(0, 32'd30);
        do_enq(1, 32'd10);
        do_enq(2, 32'd20);
        do_deq(3, 32'd10);
        do_deq(3, 32'd20);
        do_deq(3, 32'd30);

        // Fairness: all cores hold enq_req; acks 0,1,2,3,0 every 3 cycles
        do_reset();
        for (int c = 0; c < NC; c++) enq_data[c*DW +: DW] = 32'h100 + c;
        enq_req = 4'b1111;
        for (int i = 1; i <= 13; i++) begin
            logic [NC-1:0] exp_ack;
            step();
            exp_ack = ((i - 1) % 3 == 0) ? (4'b0001 << (((i - 1) / 3) % 4)) : 4'b0000;
            chk("fair_ack", 64'(enq_ack), 64'(exp_ack));
        end
        enq_req = '0;
        step();
        step();

        // Contention on a non-empty heap, last class DEQ: ENQ, DEQ, ENQ, DEQ
        do_reset();
        do_enq(0, 32'd5);
        do_enq(0, 32'd6);
        do_deq(3, 32'd5);
        enq_req[1] = 1'b1;
        enq_data[1*DW +: DW] = 32'h20;
        deq_req[2] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            logic [1:0] exp_st;
            logic [NC-1:0] exp_dv;
            step();
            exp_st = (i == 1 || i == 7) ? 2'b10 : (i == 4 || i == 10) ? 2'b01 : 2'b00;
            exp_dv = (i == 5 || i == 11) ? 4'b0100 : 4'b0000;
            chk("cont_strobes", 64'({pq_enq, pq_deq}), 64'(exp_st));
            chk("cont_deq_valid", 64'(deq_valid), 64'(exp_dv));
            if (i == 5)  chk("cont_deq_data1", 64'(deq_data), 64'h6);
            if (i == 11) chk("cont_deq_data2", 64'(deq_data), 64'h20);
        end
        enq_req = '0;
        deq_req = '0;
        step();

        // Empty heap: deq requests wait, a later enq goes first
        do_reset();
        deq_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("empty_no_deq", 64'(pq_deq), 64'd0);
        end
        do_enq(1, 32'h9);
        step();
        chk("empty_then_deq", 64'(pq_deq), 64'd1);
        step();
        chk("empty_deq_valid", 64'(deq_valid), 64'(4'b0001));
        chk("empty_deq_data", 64'(deq_data), 64'h9);
        deq_req = '0;
        step();

        // Full heap blocks enq
        force_full = 1'b1;
        enq_req[0] = 1'b1;
        enq_data[0 +: DW] = 32'h33;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("full_no_enq", 64'({pq_enq, enq_ack}), 64'd0);
        end
        force_full = 1'b0;
        step();
        chk("full_release_ack", 64'({pq_enq, enq_ack}), 64'({1'b1, 4'b0001}));
        enq_req = '0;
        step();
        step();

        // pq_ready low blocks everything
        ready_r = 1'b0;
        enq_req[2] = 1'b1;
        enq_data[2*DW +: DW] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("notready_strobes", 64'({pq_enq, pq_deq}), 64'd0);
        end
        ready_r = 1'b1;
        step();
        chk("ready_release_ack", 64'({pq_enq, enq_ack}), 64'({1'b1, 4'b0100}));
        enq_req = '0;
        step();
        step();

        // Asynchronous reset during deq ISSUE
        deq_req[1] = 1'b1;
        step();
        chk("rst_mid_issue", 64'(pq_deq), 64'd1);
        rst_n = 1'b1;
        #1;
        chk("rst_async_strobes", 64'({enq_ack, deq_valid, pq_enq, pq_deq}), 64'd0);
        chk("rst_async_inp", 64'(pq_inp_data), 64'd0);
        chk("rst_async_deq_data", 64'(deq_data), 64'd0);
        deq_req = '0;
        step();
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_valid", 64'({deq_valid, pq_deq}), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
